// File: rtl/bist_ctrl.sv
// BIST controller: drives pseudo-random requests into the arbiter under test, sequences the MISR
// (seed load, compaction, drain) and checks the final signature. Optional abort input: BIST_ABORT_EN.
module bist_ctrl #(
    parameter int              NBIT      = 8,
    parameter int              NPAT      = 255,
    parameter int              DRAIN_CYC = 2,
    parameter logic [7:0]      LFSR_SEED = 8'h01,
    parameter logic [NBIT-1:0] GOLDEN    = '0
) (
    input  logic            clk,
    input  logic            rst,
`ifdef BIST_ABORT_EN
    input  logic            abort,
`endif
    input  logic            start,
    input  logic [NBIT-1:0] signature,
    output logic [3:0]      req_o,
    output logic            bist_mode,
    output logic            misr_rst,
    output logic            busy,
    output logic            done,
    output logic            pass
);

    // The counter serves both RUN and DRAIN, so it must hold the larger of the two phase lengths.
    localparam int CNT_RUN  = $clog2(NPAT + 1);
    localparam int CNT_DRN  = $clog2(DRAIN_CYC + 1);
    localparam int CNT_MAX  = (CNT_RUN > CNT_DRN) ? CNT_RUN : CNT_DRN;
    localparam int CNT_W    = (CNT_MAX < 1) ? 1 : CNT_MAX;

    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(NPAT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
    localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_CMP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             abort_w;
    logic             in_busy;

`ifdef BIST_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_EFF;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        req_o     = 4'h0;
        bist_mode = 1'b0;
        misr_rst  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        in_busy   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    pass_d  = 1'b0;
                end
            end
            S_INIT: begin
                misr_rst  = 1'b1;
                bist_mode = 1'b1;
                busy      = 1'b1;
                in_busy   = 1'b1;
                lfsr_d    = SEED_EFF;
                cnt_d     = '0;
                pass_d    = 1'b0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                req_o     = lfsr_q[3:0];
                bist_mode = 1'b1;
                busy      = 1'b1;
                in_busy   = 1'b1;
                lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                if (cnt_q == RUN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                bist_mode = 1'b1;
                busy      = 1'b1;
                in_busy   = 1'b1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_CMP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CMP: begin
                bist_mode = 1'b1;
                busy      = 1'b1;
                in_busy   = 1'b1;
                pass_d    = (signature == GOLDEN);
                state_d   = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = S_INIT;
                    pass_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                pass_d  = 1'b0;
            end
        endcase

        // Abort overrides every other transition but only while a test is in flight.
        if (abort_w && in_busy) begin
            state_d = S_IDLE;
            lfsr_d  = SEED_EFF;
            cnt_d   = '0;
            pass_d  = 1'b0;
        end
    end

    assign pass = pass_q;

endmodule

// File: tb/tb_bist_ctrl.sv
// Self-checking bench for bist_ctrl: two instances (short run with zero seed, longer run with seed 01)
// compared cycle by cycle against a timeline model built from the controller's phase rules.
module tb_bist_ctrl;

    localparam int         NP1 = 5;
    localparam int         D1  = 2;
    localparam logic [7:0] G1  = 8'hA5;
    localparam int         NP2 = 40;
    localparam int         D2  = 3;
    localparam logic [7:0] G2  = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2;
    logic [7:0] sig1, sig2;
    logic [3:0] req1, req2;
    logic       bm1, bm2, mr1, mr2, busy1, busy2, done1, done2, pass1, pass2;
`ifdef BIST_ABORT_EN
    logic       abort1, abort2;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    bist_ctrl #(.NBIT(8), .NPAT(NP1), .DRAIN_CYC(D1), .LFSR_SEED(8'h00), .GOLDEN(G1)) u_dut1 (
        .clk(clk), .rst(rst),
`ifdef BIST_ABORT_EN
        .abort(abort1),
`endif
        .start(start1), .signature(sig1), .req_o(req1), .bist_mode(bm1),
        .misr_rst(mr1), .busy(busy1), .done(done1), .pass(pass1)
    );

    bist_ctrl #(.NBIT(8), .NPAT(NP2), .DRAIN_CYC(D2), .LFSR_SEED(8'h01), .GOLDEN(G2)) u_dut2 (
        .clk(clk), .rst(rst),
`ifdef BIST_ABORT_EN
        .abort(abort2),
`endif
        .start(start2), .signature(sig2), .req_o(req2), .bist_mode(bm2),
        .misr_rst(mr2), .busy(busy2), .done(done2), .pass(pass2)
    );

    function automatic logic [8:0] outs1();
        return {req1, bm1, mr1, busy1, done1, pass1};
    endfunction

    function automatic logic [8:0] outs2();
        return {req2, bm2, mr2, busy2, done2, pass2};
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Expected outputs per cycle from the INIT cycle onward: {req, bist_mode, misr_rst, busy, done, pass}.
    task automatic build_exp(input int npat, input int dcyc, input logic [7:0] seed,
                             input logic pv, input int ndone);
        logic [7:0] s;
        s = (seed == 8'h00) ? 8'h01 : seed;
        exp_q.delete();
        exp_q.push_back({4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < npat; i++) begin
            exp_q.push_back({s[3:0], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
            s = lfsr_step(s);
        end
        for (int i = 0; i < dcyc + 1; i++)
            exp_q.push_back({4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < ndone; i++)
            exp_q.push_back({4'h0, 1'b0, 1'b0, 1'b0, 1'b1, pv});
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (outs1() !== 9'h000) begin
            n_bad++;
            $display("FAIL reset_dut1 got=%h exp=%h", outs1(), 9'h000);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (outs2() !== 9'h000) begin
            n_bad++;
            $display("FAIL reset_dut2 got=%h exp=%h", outs2(), 9'h000);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (outs1() !== 9'h000 || outs2() !== 9'h000) begin
            n_bad++;
            $display("FAIL idle_after_reset got=%h/%h exp=000", outs1(), outs2());
        end
    endtask

    task automatic test_timing();
        sig1 = G1;
        build_exp(NP1, D1, 8'h00, 1'b1, 3);
        start1 = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            start1 = 1'b0;
            n_cmp++;
            if (outs1() !== exp_q[k]) begin
                n_bad++;
                $display("FAIL timing k=%0d got=%h exp=%h", k, outs1(), exp_q[k]);
            end
        end
    endtask

    task automatic test_pass_fail();
        logic [7:0] s;
        logic       pv;
        for (int it = 0; it < 5; it++) begin
            case (it)
                0:       s = G1 ^ (8'h01 << $urandom_range(0, 7));
                1:       s = G1;
                default: s = ($urandom_range(0, 1) == 1) ? G1 : 8'($urandom);
            endcase
            pv   = (s == G1);
            sig1 = s;
            build_exp(NP1, D1, 8'h00, pv, 2);
            start1 = 1'b1;
            for (int k = 0; k < exp_q.size(); k++) begin
                @(negedge clk);
                start1 = 1'b0;
                n_cmp++;
                if (outs1() !== exp_q[k]) begin
                    n_bad++;
                    $display("FAIL pass_fail it=%0d sig=%h k=%0d got=%h exp=%h", it, s, k, outs1(), exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_start_held();
        sig1 = G1;
        build_exp(NP1, D1, 8'h00, 1'b1, 1);
        exp_q.push_back({4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        exp_q.push_back({4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        start1 = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            n_cmp++;
            if (outs1() !== exp_q[k]) begin
                n_bad++;
                $display("FAIL start_held k=%0d got=%h exp=%h", k, outs1(), exp_q[k]);
            end
        end
        start1 = 1'b0;
        repeat (NP1 + D1 + 3) @(negedge clk);
        n_cmp++;
        if (done1 !== 1'b1) begin
            n_bad++;
            $display("FAIL start_held_done got=%b exp=1", done1);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] ref6 [6];
        logic       pv;
        ref6 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h3};
        sig2 = 8'($urandom);
        start2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start2 = 1'b0;
        end
        n_cmp++;
        if (req2 !== 4'h4) begin
            n_bad++;
            $display("FAIL pre_reset_req got=%h exp=4", req2);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (outs2() !== 9'h000 || outs1() !== 9'h000) begin
            n_bad++;
            $display("FAIL async_reset got=%h/%h exp=000", outs2(), outs1());
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pv = (sig2 == G2);
        build_exp(NP2, D2, 8'h01, pv, 2);
        start2 = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            start2 = 1'b0;
            n_cmp++;
            if (outs2() !== exp_q[k]) begin
                n_bad++;
                $display("FAIL restart k=%0d got=%h exp=%h", k, outs2(), exp_q[k]);
            end
            if (k >= 1 && k <= 6) begin
                n_cmp++;
                if (req2 !== ref6[k-1]) begin
                    n_bad++;
                    $display("FAIL restart_pat k=%0d got=%h exp=%h", k, req2, ref6[k-1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic pv;
        for (int it = 0; it < 3; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sig2 = ($urandom_range(0, 1) == 1) ? G2 : (G2 ^ 8'($urandom_range(1, 255)));
            pv   = (sig2 == G2);
            build_exp(NP2, D2, 8'h01, pv, 1);
            start2 = 1'b1;
            for (int k = 0; k < exp_q.size(); k++) begin
                @(negedge clk);
                start2 = 1'b0;
                n_cmp++;
                if (outs2() !== exp_q[k]) begin
                    n_bad++;
                    $display("FAIL back_to_back it=%0d k=%0d got=%h exp=%h", it, k, outs2(), exp_q[k]);
                end
            end
        end
    endtask

`ifdef BIST_ABORT_EN
    task automatic test_abort();
        sig2 = G2;
        start2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start2 = 1'b0;
        end
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        n_cmp++;
        if (outs2() !== 9'h000) begin
            n_bad++;
            $display("FAIL abort got=%h exp=000", outs2());
        end
        @(negedge clk);
        n_cmp++;
        if (outs2() !== 9'h000) begin
            n_bad++;
            $display("FAIL abort_hold got=%h exp=000", outs2());
        end
    endtask
`endif

    initial begin
        rst    = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        sig1   = 8'h00;
        sig2   = 8'h00;
`ifdef BIST_ABORT_EN
        abort1 = 1'b0;
        abort2 = 1'b0;
`endif
        test_reset();
        test_timing();
        test_pass_fail();
        test_start_held();
        test_reset_mid_run();
        test_back_to_back();
`ifdef BIST_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bist_ctrl.md
# bist_ctrl

BIST controller that drives the 4-way arbiter under test with pseudo-random request patterns. It sequences the downstream MISR through seed load, compaction and drain, then compares the final MISR signature against a golden value. It sits on both sides of the arbiter: its `req_o` replaces functional requests while `bist_mode` is high, and it consumes the MISR `signature` and drives the MISR's synchronous seed load.

## Interface
- `NBIT`, 8: MISR signature width.
- `NPAT`, 255: number of pattern cycles applied in RUN; legal range 1 to 65535.
- `DRAIN_CYC`, 2: idle cycles after the last pattern, so the final grant reaches the MISR; minimum 1.
- `LFSR_SEED`, 8'h01: TPG seed; a value of 0 is replaced by 8'h01.
- `GOLDEN`, 8'h00: expected signature; overridden per netlist.

- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  level; starts a test when sampled high in IDLE or DONE.
- `signature`  in  NBIT  MISR signature.
- `req_o`  out  4  test request vector to the arbiter.
- `bist_mode`  out  1  request-mux select; high from INIT through CMP.
- `misr_rst`  out  1  MISR seed load; high only in INIT.
- `busy`  out  1  high in INIT, RUN, DRAIN and CMP.
- `done`  out  1  high in DONE.
- `pass`  out  1  comparison result; valid while `done`=1.

## Operation
- FSM states: IDLE → INIT → RUN → DRAIN → CMP → DONE.
- IDLE: all outputs 0. `start`=1 moves to INIT.
- INIT (1 cycle):
  - `misr_rst`=1.
  - LFSR loads the seed.
  - Pattern counter clears.
  - `pass` clears.
- RUN (exactly NPAT cycles):
  - `req_o` = `lfsr[3:0]`.
  - The LFSR advances every cycle.
  - The counter increments every cycle.
  - After the cycle with count == NPAT-1, the FSM moves to DRAIN.
- TPG: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
  - Update: `lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`.
  - Maximal period 255. The all-zero state is unreachable.
- DRAIN (DRAIN_CYC cycles): `req_o`=0 and `bist_mode`=1. Reuses the counter, cleared on entry.
- CMP (1 cycle): `pass` <= (`signature` == GOLDEN).
- DONE:
  - `done`=1; `pass` is held.
  - `start`=1 restarts the test at INIT.
  - `start`=0 holds DONE indefinitely.
- `start` is ignored while `busy`=1.
- Counter width: `$clog2(NPAT+1)`, minimum 1. The counter does not wrap inside one phase.
- Reset mid-test: asynchronous return to IDLE, all outputs 0, LFSR = seed. No partial result is retained.

## Timing
- `start` high at edge t (IDLE) → INIT during cycle t+1.
- First pattern (seed) is on `req_o` during cycle t+2.
- Last pattern is during cycle t+1+NPAT.
- DRAIN covers cycles t+2+NPAT to t+1+NPAT+DRAIN_CYC.
- CMP is at cycle t+2+NPAT+DRAIN_CYC.
- `done`/`pass` are valid from cycle t+3+NPAT+DRAIN_CYC.
- All outputs are registered or decoded from registered state only; no combinational path from `signature` or `start` to any output.
- Reset values: `req_o`=0, `bist_mode`=0, `misr_rst`=0, `busy`=0, `done`=0, `pass`=0.

## Configuration
- `BIST_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 sampled in any busy state returns the FSM to IDLE on the next edge, with `pass`=0 and `done`=0.
  - `abort` has priority over all other transitions.
  - `abort` in IDLE or DONE has no effect.
- `BIST_ABORT_EN` undefined: the port does not exist and the FSM runs to completion once started.

## Test plan
- Reset while RUN, with `req_o` nonzero → all outputs 0 asynchronously. A restart reproduces `req_o` = 1,2,4,8,1,3 for seed 8'h01.
- NPAT=5, DRAIN_CYC=2, `start` pulse at t:
  - `misr_rst` high only at t+1.
  - `req_o` = 1,2,4,8,1 over t+2..t+6.
  - `req_o`=0 at t+7..t+8; CMP at t+9; `done` at t+10.
- Full run with the MISR and arbiter connected and GOLDEN set from the reference model → `pass`=1. GOLDEN with one bit flipped → `pass`=0, `done`=1.
- `start` held high through the whole test → no restart while busy. Re-enters INIT on the cycle after DONE is first reached.
- LFSR_SEED=0 → first RUN pattern is 1, identical to seed 8'h01.
- With `BIST_ABORT_EN`, `abort` pulsed in the third RUN cycle → IDLE next edge, `req_o`=0, `busy`=0, `done`=0, `pass`=0. Build without it has no `abort` port.
